// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: FSM encodings, default
// parameter values and the zero word used by the init sweep and read muxes.
package regfile_mp_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NRD    = 4;

    localparam logic [0:0] INIT_S = 1'b0;
    localparam logic [0:0] RUN_S  = 1'b1;

    // Wide enough for any practical DATA_W; users slice the low DATA_W bits.
    localparam int                ZERO_W   = 256;
    localparam logic [ZERO_W-1:0] ZeroWord = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by alloc, cleared by
// a write; reports busy for each read port.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NRD    = DEF_NRD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  alloc_en,
    input  logic [ADDR_W-1:0]     alloc_addr,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD-1:0]        busy
);

    localparam int NREG = 2**ADDR_W;

    logic [NREG-1:0] pending_reg;
    logic [NREG-1:0] pending_next;

    // Clears are applied before the set so a same-cycle alloc wins.
    always_comb begin
        pending_next = pending_reg;
        if (run) begin
            if (we0) pending_next[waddr0] = 1'b0;
            if (we1) pending_next[waddr1] = 1'b0;
            if (alloc_en && alloc_addr != '0) pending_next[alloc_addr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_busy
            logic [ADDR_W-1:0] ra;
            assign ra       = raddr[gi*ADDR_W +: ADDR_W];
            assign busy[gi] = re[gi] && (ra != '0) && pending_reg[ra];
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 younger), NRD bypassing
// combinational read ports, zeroing init sweep after reset. The pending-write
// scoreboard is compiled in with REGFILE_SCOREBOARD_EN.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NRD    = DEF_NRD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic                  ready,
    input  logic                  alloc_en,
    input  logic [ADDR_W-1:0]     alloc_addr,
    output logic [NRD-1:0]        busy
);

    localparam int NREG = 2**ADDR_W;

    logic [0:0]        state_reg;
    logic [0:0]        state_next;
    logic [ADDR_W-1:0] cnt_reg;
    logic              run;

    assign run   = (state_reg == RUN_S);
    assign ready = run;

    always_comb begin
        state_next = state_reg;
        if (!run && cnt_reg == ADDR_W'(NREG-1)) state_next = RUN_S;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= INIT_S;
            cnt_reg   <= ADDR_W'(1);
        end else begin
            state_reg <= state_next;
            if (!run) cnt_reg <= cnt_reg + ADDR_W'(1);
        end
    end

    // Storage is deliberately not reset; the sweep zeroes it one entry per cycle.
    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (!run) begin
            regs[cnt_reg] <= ZeroWord[DATA_W-1:0];
        end else begin
            if (we0 && waddr0 != '0) regs[waddr0] <= wdata0;
            if (we1 && waddr1 != '0) regs[waddr1] <= wdata1;
        end
    end

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rd_word;

            assign ra = raddr[gi*ADDR_W +: ADDR_W];

            always_comb begin
                rd_word = ZeroWord[DATA_W-1:0];
                if (run && re[gi] && ra != '0) begin
                    if (we1 && ra == waddr1)      rd_word = wdata1;
                    else if (we0 && ra == waddr0) rd_word = wdata0;
                    else                          rd_word = regs[ra];
                end
            end

            assign rdata[gi*DATA_W +: DATA_W] = rd_word;
        end
    endgenerate

`ifdef REGFILE_SCOREBOARD_EN
    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NRD    (NRD)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .we0        (we0),
        .waddr0     (waddr0),
        .we1        (we1),
        .waddr1     (waddr1),
        .re         (re),
        .raddr      (raddr),
        .busy       (busy)
    );
`else
    logic unused_alloc;
    assign unused_alloc = ^{alloc_en, alloc_addr};
    assign busy         = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected outputs tagged
// with the cycle they belong to; a monitor pops and compares on the falling edge.
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              we0, we1;
    logic [AW-1:0]     waddr0, waddr1;
    logic [DW-1:0]     wdata0, wdata1;
    logic [NRD-1:0]    re;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic              ready;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic [NRD-1:0]    busy;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) dut (
        .clk        (clk),
        .rst        (rst),
        .we0        (we0),
        .we1        (we1),
        .waddr0     (waddr0),
        .waddr1     (waddr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .re         (re),
        .raddr      (raddr),
        .rdata      (rdata),
        .ready      (ready),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    localparam int K_RDATA = 0;
    localparam int K_READY = 1;
    localparam int K_BUSY  = 2;

    typedef struct {
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic string kname(int kind);
        if (kind == K_RDATA) return "rdata";
        if (kind == K_READY) return "ready";
        return "busy";
    endfunction

    // Expected busy vector: pending tracking exists only with the scoreboard built in.
    function automatic logic [31:0] sb(logic [3:0] v);
`ifdef REGFILE_SCOREBOARD_EN
        return {28'b0, v};
`else
        return {28'b0, 4'b0 & v};
`endif
    endfunction

    task automatic push(input int kind, input int port, input logic [31:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.port = port;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        re = '0; raddr = '0; alloc_en = 0; alloc_addr = '0;
    endtask

    task automatic rd(input int port, input int addr);
        re[port] = 1'b1;
        raddr[port*AW +: AW] = AW'(addr);
    endtask

    task automatic sb_reads();
        rd(0, 3);
        rd(1, 4);
        raddr[2*AW +: AW] = AW'(3);
        rd(3, 3);
    endtask

    // Monitor: compare every expectation tagged with the current cycle.
    initial forever begin : monitor
        exp_t        e;
        logic [31:0] act;
        @(negedge clk);
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.kind == K_RDATA)      act = rdata[e.port*DW +: DW];
            else if (e.kind == K_READY) act = {31'b0, ready};
            else                        act = {28'b0, busy};
            checks++;
            if (e.cyc != cyc || act !== e.val) begin
                errors++;
                $display("FAIL %s port %0d cycle %0d (sampled %0d): got %h expected %h",
                         kname(e.kind), e.port, e.cyc, cyc, act, e.val);
            end else begin
                $display("ok   %s port %0d cycle %0d: %h", kname(e.kind), e.port, cyc, act);
            end
        end
    end

    initial begin
        idle();
        rst = 1'b0;

        // In reset
        step();
        rd(0, 5);
        push(K_READY, 0, 0);
        push(K_RDATA, 0, 0);
        push(K_BUSY, 0, 0);
        step();

        // Release: 31 cycles of INIT then ready
        rst = 1'b1;
        for (int i = 0; i < 31; i++) begin
            push(K_READY, 0, 0);
            if (i == 5) push(K_RDATA, 0, 0);
            step();
        end
        idle();
        push(K_READY, 0, 1);

        // Every register reads zero after the sweep
        for (int b = 0; b < 8; b++) begin
            idle();
            for (int p = 0; p < NRD; p++) begin
                rd(p, b*4 + p);
                push(K_RDATA, p, 0);
            end
            step();
        end

        // Dual write same address: younger port wins, bypass and stored
        idle();
        we0 = 1; waddr0 = 5; wdata0 = 32'h1111_1111;
        we1 = 1; waddr1 = 5; wdata1 = 32'h2222_2222;
        rd(0, 5); rd(1, 5);
        push(K_RDATA, 0, 32'h2222_2222);
        push(K_RDATA, 1, 32'h2222_2222);
        step();
        idle();
        rd(2, 5);
        push(K_RDATA, 2, 32'h2222_2222);
        step();

        // Two different addresses in one cycle
        idle();
        we0 = 1; waddr0 = 10; wdata0 = 32'hAAAA_0010;
        we1 = 1; waddr1 = 11; wdata1 = 32'hBBBB_0011;
        rd(0, 10); rd(1, 11); rd(3, 12);
        push(K_RDATA, 0, 32'hAAAA_0010);
        push(K_RDATA, 1, 32'hBBBB_0011);
        push(K_RDATA, 3, 0);
        step();
        idle();
        rd(0, 11); rd(1, 10);
        push(K_RDATA, 0, 32'hBBBB_0011);
        push(K_RDATA, 1, 32'hAAAA_0010);
        step();

        // Bypass to all four ports
        idle();
        we0 = 1; waddr0 = 7; wdata0 = 32'hDEAD_BEEF;
        for (int p = 0; p < NRD; p++) begin
            rd(p, 7);
            push(K_RDATA, p, 32'hDEAD_BEEF);
        end
        step();
        idle();
        rd(0, 7);
        raddr[1*AW +: AW] = AW'(7);
        push(K_RDATA, 0, 32'hDEAD_BEEF);
        push(K_RDATA, 1, 0);
        step();

        // Port 1 alone overwrites r7
        idle();
        we1 = 1; waddr1 = 7; wdata1 = 32'hCAFE_F00D;
        rd(0, 7);
        push(K_RDATA, 0, 32'hCAFE_F00D);
        step();
        idle();
        rd(2, 7);
        push(K_RDATA, 2, 32'hCAFE_F00D);
        step();

        // r0 is never written
        idle();
        we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF;
        we1 = 1; waddr1 = 0; wdata1 = 32'h1234_5678;
        rd(0, 0);
        push(K_RDATA, 0, 0);
        step();
        idle();
        rd(0, 0);
        push(K_RDATA, 0, 0);
        step();

        // Scoreboard: alloc, write-clear, alloc+write same cycle
        idle();
        alloc_en = 1; alloc_addr = 3;
        sb_reads();
        push(K_BUSY, 0, 0);
        step();
        idle();
        sb_reads();
        push(K_BUSY, 0, sb(4'b1001));
        step();
        idle();
        we0 = 1; waddr0 = 3; wdata0 = 32'h0000_0033;
        sb_reads();
        push(K_BUSY, 0, sb(4'b1001));
        step();
        idle();
        sb_reads();
        push(K_BUSY, 0, 0);
        step();
        idle();
        alloc_en = 1; alloc_addr = 3;
        we1 = 1; waddr1 = 3; wdata1 = 32'h0000_0333;
        sb_reads();
        push(K_BUSY, 0, 0);
        step();
        idle();
        sb_reads();
        push(K_BUSY, 0, sb(4'b1001));
        push(K_RDATA, 0, 32'h0000_0333);
        step();
        idle();
        alloc_en = 1; alloc_addr = 0;
        rd(0, 0);
        step();
        idle();
        rd(0, 0);
        push(K_BUSY, 0, 0);
        step();

        // Reset during RUN, then again at sweep cycle 10; INIT writes are lost
        idle();
        rst = 1'b0;
        rd(0, 3); rd(1, 7);
        push(K_READY, 0, 0);
        push(K_BUSY, 0, 0);
        push(K_RDATA, 0, 0);
        push(K_RDATA, 1, 0);
        step();
        rst = 1'b1;
        idle();
        we0 = 1; waddr0 = 9; wdata0 = 32'h9999_9999;
        we1 = 1; waddr1 = 7; wdata1 = 32'h7777_7777;
        alloc_en = 1; alloc_addr = 4;
        rd(0, 9); rd(1, 7);
        for (int i = 0; i < 10; i++) begin
            push(K_READY, 0, 0);
            if (i == 0 || i == 9) push(K_RDATA, 0, 0);
            step();
        end
        rst = 1'b0;
        push(K_READY, 0, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 31; i++) begin
            push(K_READY, 0, 0);
            if (i == 30) push(K_RDATA, 1, 0);
            step();
        end
        idle();
        push(K_READY, 0, 1);
        rd(0, 9); rd(1, 7); rd(2, 3); rd(3, 4);
        for (int p = 0; p < NRD; p++) push(K_RDATA, p, 0);
        push(K_BUSY, 0, 0);
        step();

        idle();
        step();
        step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; register count NREG = 2**ADDR_W.
REQ-003 Parameter NRD, default 4, number of read ports.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-006 we0/we1  input  1 each  write enables; port 1 is the younger write.
REQ-007 waddr0/waddr1  input  ADDR_W each  write addresses.
REQ-008 wdata0/wdata1  input  DATA_W each  write data.
REQ-009 re  input  NRD  per-port read enables.
REQ-010 raddr  input  NRD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-011 rdata  output  NRD*DATA_W  packed read data; same packing as raddr.
REQ-012 ready  output  1  high once the init sweep has completed.
REQ-013 alloc_en  input  1  scoreboard allocate strobe.
REQ-014 alloc_addr  input  ADDR_W  register marked pending by alloc_en.
REQ-015 busy  output  NRD  per-read-port pending flag for raddr.

Function
REQ-016 The FSM SHALL have two states, INIT and RUN; reset forces INIT with sweep counter = 1.
REQ-017 In INIT, the block SHALL write zero to register[counter] each cycle and increment the counter.
REQ-018 The FSM SHALL go to RUN on the cycle after counter = NREG-1 is cleared; INIT lasts exactly NREG-1 cycles.
REQ-019 ready SHALL be 1 only in RUN.
REQ-020 In INIT, we0, we1 and alloc_en SHALL be ignored, and all rdata SHALL be zero.
REQ-021 In RUN, a write SHALL update register[waddr] at the clock edge when its enable is 1 and its waddr != 0.
REQ-022 When both ports write the same nonzero address in one cycle, wdata1 SHALL be stored.
REQ-023 Read port k SHALL be combinational.
REQ-024 Read port k SHALL return 0 if re[k]=0 or its raddr=0.
REQ-025 Otherwise, read port k SHALL return wdata1 if we1 is high and its raddr equals waddr1.
REQ-026 Otherwise, read port k SHALL return wdata0 if we0 is high and its raddr equals waddr0.
REQ-027 Otherwise, read port k SHALL return the stored register value.
REQ-028 Register 0 SHALL read as zero and SHALL never be written.
REQ-029 A reset asserted mid-sweep or during RUN SHALL restart INIT from counter = 1.

Reset
REQ-030 While rst=0: ready=0, all rdata=0, busy=0, FSM in INIT, and all scoreboard bits cleared.
REQ-031 Register storage SHALL be zeroed by the INIT sweep, not by the asynchronous reset.

Configuration
REQ-032 Macro REGFILE_SCOREBOARD_EN compiled in:
- an alloc_en with nonzero alloc_addr in RUN SHALL set pending[alloc_addr] at the next edge;
- a RUN write to an address SHALL clear that address's pending bit;
- if alloc and a write target the same register in one cycle, the set SHALL win;
- busy[k] SHALL equal pending[raddr_k] AND re[k], and busy SHALL be 0 for address 0.
REQ-033 Macro REGFILE_SCOREBOARD_EN absent: the alloc ports SHALL be present but unused, busy SHALL be tied to 0, and no pending storage SHALL exist.

Structure
REQ-034 Shared package/defines SHALL hold:
- the state encodings INIT_S and RUN_S;
- the default parameter values;
- the ZeroWord constant.
REQ-035 The scoreboard SHALL be a sub-module, regfile_scoreboard, instantiated only under REGFILE_SCOREBOARD_EN.

Verification
REQ-036 Init sweep: deassert rst -> ready=0 for 31 cycles, ready=1 on cycle 32, and every register reads 0.
REQ-037 Dual write, same address: we0 and we1 to r5 with 0x11111111 / 0x22222222 -> r5 reads 0x22222222 on the next cycle; same cycle bypass on a read of r5 returns 0x22222222.
REQ-038 Bypass and zero register: write r7=0xDEADBEEF; all 4 ports read r7 in the same cycle -> all return 0xDEADBEEF; a write to r0 -> r0 still reads 0.
REQ-039 Reset mid-sweep: rst low at sweep cycle 10, released -> full 31-cycle INIT restarts, and a write attempted during INIT is lost.
REQ-040 Scoreboard (macro on): alloc r3 -> busy=1 on ports reading r3 next cycle; write r3 -> busy=0 after the edge; alloc and write r3 in the same cycle -> busy stays 1.
